mpu_bus_arbiter: RTL and testbench
==================================

MPU_BUS_ARBITER -- requirements
Module: mpu_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter: MAX_BURST, default 8, the maximum number of consecutive DMA grant cycles (used only when ARB_BURST_LIMIT_EN is defined).
REQ-002 The block SHALL have one parameter: MIN_GAP, default 4, the minimum number of MPU-owned cycles after a forced release (used only when ARB_BURST_LIMIT_EN is defined).
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be as follows, in this order:
- CLK  in  1  clock; all state changes on the rising edge.
- RES  in  1  asynchronous active-high reset.
- MPU_R_W  in  1  MPU read(1)/write(0).
- MPU_ABL  in  8  MPU address bus, low byte.
- MPU_ABH  in  8  MPU address bus, high byte.
- MPU_DB_OUT  in  8  MPU write data.
- MPU_RDY  out  1  ready line to the MPU.
- DMA_REQ  in  1  DMA bus request, level-held.
- DMA_R_W  in  1  DMA read(1)/write(0).
- DMA_ADDR  in  16  DMA address.
- DMA_DB_OUT  in  8  DMA write data.
- DMA_GNT  out  1  DMA owns the bus this cycle.
- MEM_R_W  out  1  muxed memory read/write.
- MEM_ADDR  out  16  muxed memory address.
- MEM_DB_OUT  out  8  muxed memory write data.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, HALT, GRANT and RELEASE.
REQ-006 In IDLE: MPU_RDY=1, DMA_GNT=0, MEM_*=MPU_* ({MPU_ABH,MPU_ABL} on MEM_ADDR); DMA_REQ=1 -> HALT at the next edge.
REQ-007 In HALT: MPU_RDY=0, DMA_GNT=0, MEM_*=MPU_*; MPU_R_W=1 sampled at an edge -> GRANT; MPU_R_W=0 -> remain in HALT. Writes are not stalled by RDY, so the block waits out write cycles of any length.
REQ-008 A drop of DMA_REQ while in HALT SHALL NOT cancel the transition; at the next edge the FSM enters GRANT with zero beats and goes straight to RELEASE.
REQ-009 In GRANT: MPU_RDY=0, DMA_GNT=1, MEM_R_W=DMA_R_W, MEM_ADDR=DMA_ADDR, MEM_DB_OUT=DMA_DB_OUT; each GRANT cycle is one DMA beat.
REQ-010 GRANT -> RELEASE when DMA_REQ=0 is sampled, or when the burst limit of REQ-017 is reached.
REQ-011 In RELEASE: MPU_RDY=0, DMA_GNT=0, MEM_*=MPU_*, lasting exactly 1 cycle, then -> IDLE. This re-presents the stalled MPU read address one cycle before RDY rises.
REQ-012 Handshake latency: DMA_REQ rising in IDLE -> DMA_GNT high at least 2 edges later. DMA_GNT low -> MPU_RDY high exactly 1 cycle later.
REQ-013 MEM_* and DMA_GNT SHALL be combinational from the state register; MPU_RDY SHALL be decoded from the state register only (no input-to-RDY path).
REQ-014 DMA_GNT and MEM source selection SHALL never disagree in any cycle.

Reset
REQ-015 While RES=1: state=IDLE, MPU_RDY=1, DMA_GNT=0, MEM_*=MPU_*, burst and gap counters cleared.
REQ-016 RES asserted in any state, including mid-GRANT, SHALL abort immediately, with no RELEASE cycle; the first edge after deassertion is evaluated from IDLE.

Configuration
REQ-017 With ARB_BURST_LIMIT_EN defined: a 0..MAX_BURST beat counter increments per GRANT cycle; at MAX_BURST beats the FSM goes to RELEASE regardless of DMA_REQ, and a gap counter then holds IDLE and ignores DMA_REQ for MIN_GAP cycles.
REQ-018 Without ARB_BURST_LIMIT_EN: GRANT lasts while DMA_REQ=1, unbounded, and no counters are synthesized; MAX_BURST and MIN_GAP are ignored.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- MPU reading 0x1234, DMA_REQ pulse with 3 beats to 0x0200-0x0202 (writes 0xA5) -> HALT 1 cycle, GNT 3 cycles, MEM_ADDR 0x0200/01/02, RELEASE with MEM_ADDR 0x1234, RDY high.
- DMA_REQ during 3 consecutive MPU writes (0x01FD-0x01FB) -> HALT held 3 cycles with writes passing to MEM, GRANT only after MPU_R_W=1.
- ARB_BURST_LIMIT_EN, MAX_BURST=8, MIN_GAP=4, DMA_REQ held high 20 cycles -> GNT exactly 8 cycles, RELEASE, 4 IDLE cycles with RDY=1, then HALT again.
- Without macro, same stimulus -> GNT continuous until DMA_REQ falls.
- RES pulsed on 2nd GRANT cycle -> same cycle RDY=1, GNT=0, MEM_ADDR=MPU address; no RELEASE cycle observed.
- DMA_REQ dropped during HALT -> one GRANT cycle, then RELEASE, then IDLE; no beat counted.

Source files
------------

// File: rtl/mpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mpu_bus_arbiter
// Description : Shares one memory bus between an MPU and a DMA engine.
//               DMA_REQ moves IDLE -> HALT; HALT waits for an MPU read cycle
//               (writes are never stalled), then GRANT hands the bus to the
//               DMA one beat per cycle; RELEASE re-presents the stalled MPU
//               address for one cycle before MPU_RDY rises again.
// Ports       : CLK, RES (async, active-high)
//               MPU_R_W/MPU_ABL/MPU_ABH/MPU_DB_OUT in, MPU_RDY out
//               DMA_REQ/DMA_R_W/DMA_ADDR/DMA_DB_OUT in, DMA_GNT out
//               MEM_R_W/MEM_ADDR/MEM_DB_OUT out (muxed bus)
// Options     : ARB_BURST_LIMIT_EN - caps a grant at MAX_BURST beats and,
//               after such a forced release, keeps the MPU on the bus for
//               MIN_GAP IDLE cycles before another request is honoured.
// Revision    : 1.0 - initial release
// ============================================================================
module mpu_bus_arbiter #(
    parameter int MAX_BURST = 8,
    parameter int MIN_GAP   = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        MPU_R_W,
    input  logic [7:0]  MPU_ABL,
    input  logic [7:0]  MPU_ABH,
    input  logic [7:0]  MPU_DB_OUT,
    output logic        MPU_RDY,
    input  logic        DMA_REQ,
    input  logic        DMA_R_W,
    input  logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DB_OUT,
    output logic        DMA_GNT,
    output logic        MEM_R_W,
    output logic [15:0] MEM_ADDR,
    output logic [7:0]  MEM_DB_OUT
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_HALT    = 2'd1;
    localparam logic [1:0] c_ST_GRANT   = 2'd2;
    localparam logic [1:0] c_ST_RELEASE = 2'd3;

    logic [1:0] r_state;
    logic       w_dma_sel;
    logic       w_burst_done;
    logic       w_gap_open;

`ifdef ARB_BURST_LIMIT_EN
    localparam int c_BEAT_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
    localparam int c_GAP_W  = (MIN_GAP < 2) ? 1 : $clog2(MIN_GAP + 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(MAX_BURST - 1);
    localparam logic [c_BEAT_W-1:0] c_BEAT_ONE  = c_BEAT_W'(1);
    localparam logic [c_GAP_W-1:0]  c_GAP_INIT  = c_GAP_W'(MIN_GAP);
    localparam logic [c_GAP_W-1:0]  c_GAP_ONE   = c_GAP_W'(1);

    logic [c_BEAT_W-1:0] r_beats;
    logic [c_GAP_W-1:0]  r_gap;

    // Only beats with DMA_REQ still high are counted, so a request dropped
    // during HALT produces a zero-beat grant.
    assign w_burst_done = DMA_REQ && (r_beats == c_BEAT_LAST);
    // The last gap cycle may already accept a request, giving exactly
    // MIN_GAP IDLE cycles between RELEASE and the next HALT.
    assign w_gap_open   = (r_gap <= c_GAP_ONE);
`else
    logic w_params_unused;

    assign w_params_unused = (MAX_BURST > 0) ^ (MIN_GAP > 0);
    assign w_burst_done    = 1'b0;
    assign w_gap_open      = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= c_ST_IDLE;
`ifdef ARB_BURST_LIMIT_EN
            r_beats <= '0;
            r_gap   <= '0;
`endif
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (DMA_REQ && w_gap_open) begin
                        r_state <= c_ST_HALT;
                    end
`ifdef ARB_BURST_LIMIT_EN
                    if (r_gap != '0) begin
                        r_gap <= r_gap - c_GAP_ONE;
                    end
`endif
                end
                // Wait for a read cycle; the MPU only honours RDY on reads.
                c_ST_HALT: begin
                    if (MPU_R_W) begin
                        r_state <= c_ST_GRANT;
                    end
                end
                c_ST_GRANT: begin
`ifdef ARB_BURST_LIMIT_EN
                    if (DMA_REQ) begin
                        r_beats <= r_beats + c_BEAT_ONE;
                    end
`endif
                    if (!DMA_REQ || w_burst_done) begin
                        r_state <= c_ST_RELEASE;
`ifdef ARB_BURST_LIMIT_EN
                        r_beats <= '0;
                        if (w_burst_done) begin
                            r_gap <= c_GAP_INIT;
                        end
`endif
                    end
                end
                c_ST_RELEASE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // One select bit drives both the grant flag and the bus mux, so the two
    // can never disagree.
    assign w_dma_sel  = (r_state == c_ST_GRANT);
    assign DMA_GNT    = w_dma_sel;
    assign MPU_RDY    = (r_state == c_ST_IDLE);
    assign MEM_R_W    = w_dma_sel ? DMA_R_W    : MPU_R_W;
    assign MEM_ADDR   = w_dma_sel ? DMA_ADDR   : {MPU_ABH, MPU_ABL};
    assign MEM_DB_OUT = w_dma_sel ? DMA_DB_OUT : MPU_DB_OUT;

endmodule
`default_nettype wire

// File: tb/tb_mpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mpu_bus_arbiter
// Description : Directed, table-driven bench for mpu_bus_arbiter. Each vector
//               holds the inputs for one clock cycle and the arbiter state
//               expected during that cycle; expected outputs follow from that
//               state and the driven inputs. Reset abort is a hand sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mpu_bus_arbiter;

    localparam logic [1:0] c_I = 2'd0;
    localparam logic [1:0] c_H = 2'd1;
    localparam logic [1:0] c_G = 2'd2;
    localparam logic [1:0] c_R = 2'd3;

    typedef struct {
        logic        mrw;
        logic [15:0] maddr;
        logic [7:0]  mdb;
        logic        req;
        logic        drw;
        logic [15:0] daddr;
        logic [7:0]  ddb;
        logic [1:0]  st;
    } vec_t;

    logic        clk = 1'b0;
    logic        res;
    logic        mpu_r_w;
    logic [15:0] mpu_addr;
    logic [7:0]  mpu_db_out;
    logic        dma_req;
    logic        dma_r_w;
    logic [15:0] dma_addr;
    logic [7:0]  dma_db_out;
    logic        mpu_rdy;
    logic        dma_gnt;
    logic        mem_r_w;
    logic [15:0] mem_addr;
    logic [7:0]  mem_db_out;

    int n_checks = 0;
    int n_err    = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mpu_bus_arbiter #(
        .MAX_BURST (8),
        .MIN_GAP   (4)
    ) dut (
        .CLK        (clk),
        .RES        (res),
        .MPU_R_W    (mpu_r_w),
        .MPU_ABL    (mpu_addr[7:0]),
        .MPU_ABH    (mpu_addr[15:8]),
        .MPU_DB_OUT (mpu_db_out),
        .MPU_RDY    (mpu_rdy),
        .DMA_REQ    (dma_req),
        .DMA_R_W    (dma_r_w),
        .DMA_ADDR   (dma_addr),
        .DMA_DB_OUT (dma_db_out),
        .DMA_GNT    (dma_gnt),
        .MEM_R_W    (mem_r_w),
        .MEM_ADDR   (mem_addr),
        .MEM_DB_OUT (mem_db_out)
    );

    function automatic vec_t mk(input logic mrw, input logic [15:0] maddr,
                                input logic [7:0] mdb, input logic req,
                                input logic drw, input logic [15:0] daddr,
                                input logic [7:0] ddb, input logic [1:0] st);
        vec_t v;
        v.mrw = mrw; v.maddr = maddr; v.mdb = mdb; v.req = req;
        v.drw = drw; v.daddr = daddr; v.ddb = ddb; v.st = st;
        return v;
    endfunction

    // Expected state of cycle i while DMA_REQ is held high from IDLE.
    function automatic logic [1:0] burst_st(input int i);
        if (i == 0) return c_I;
        if (i == 1) return c_H;
`ifdef ARB_BURST_LIMIT_EN
        if (i <= 9)  return c_G;
        if (i == 10) return c_R;
        if (i <= 14) return c_I;
        if (i == 15) return c_H;
`endif
        return c_G;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [1:0] st);
        logic [24:0] exp_mem;
        exp_mem = (st == c_G) ? {dma_r_w, dma_addr, dma_db_out}
                              : {mpu_r_w, mpu_addr, mpu_db_out};
        check({name, ".rdy"}, 32'(mpu_rdy), 32'(st == c_I));
        check({name, ".gnt"}, 32'(dma_gnt), 32'(st == c_G));
        check({name, ".mem"}, 32'({mem_r_w, mem_addr, mem_db_out}), 32'(exp_mem));
    endtask

    task automatic drive(input vec_t v);
        mpu_r_w = v.mrw; mpu_addr = v.maddr; mpu_db_out = v.mdb;
        dma_req = v.req; dma_r_w = v.drw; dma_addr = v.daddr; dma_db_out = v.ddb;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin : main
        // Reset with an MPU read of 0x1234 on the bus.
        res = 1'b1;
        drive(mk(1'b1, 16'h1234, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, c_I));
        @(negedge clk);
        check_state("reset", c_I);
        @(posedge clk); #1;
        res = 1'b0;

        // 3-beat DMA write burst while the MPU reads 0x1234.
        tbl.push_back(mk(1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, c_I));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 1, 0, 16'h0000, 8'h00, c_I));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 1, 0, 16'h0000, 8'h00, c_H));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 1, 0, 16'h0200, 8'hA5, c_G));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 1, 0, 16'h0201, 8'hA5, c_G));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 0, 0, 16'h0202, 8'hA5, c_G));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, c_R));
        tbl.push_back(mk(1, 16'h1234, 8'h00, 0, 0, 16'h0000, 8'h00, c_I));
        // Request during three MPU writes: HALT waits them out.
        tbl.push_back(mk(1, 16'h0300, 8'h00, 1, 1, 16'h0400, 8'h00, c_I));
        tbl.push_back(mk(0, 16'h01FD, 8'h11, 1, 1, 16'h0400, 8'h00, c_H));
        tbl.push_back(mk(0, 16'h01FC, 8'h22, 1, 1, 16'h0400, 8'h00, c_H));
        tbl.push_back(mk(0, 16'h01FB, 8'h33, 1, 1, 16'h0400, 8'h00, c_H));
        tbl.push_back(mk(1, 16'h0305, 8'h00, 1, 1, 16'h0400, 8'h00, c_H));
        tbl.push_back(mk(1, 16'h0305, 8'h00, 0, 1, 16'h0400, 8'h77, c_G));
        tbl.push_back(mk(1, 16'h0305, 8'h00, 0, 1, 16'h0400, 8'h00, c_R));
        tbl.push_back(mk(1, 16'h0305, 8'h00, 0, 1, 16'h0400, 8'h00, c_I));
        // Request dropped during HALT: one zero-beat GRANT, then RELEASE.
        tbl.push_back(mk(1, 16'h2000, 8'h00, 1, 0, 16'h0900, 8'h00, c_I));
        tbl.push_back(mk(1, 16'h2000, 8'h00, 0, 0, 16'h0900, 8'h00, c_H));
        tbl.push_back(mk(1, 16'h2000, 8'h00, 0, 1, 16'h0900, 8'h5A, c_G));
        tbl.push_back(mk(1, 16'h2000, 8'h00, 0, 0, 16'h0900, 8'h00, c_R));
        tbl.push_back(mk(1, 16'h2000, 8'h00, 0, 0, 16'h0900, 8'h00, c_I));
        // DMA_REQ held 20 cycles, then dropped.
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(1, 16'h5555, 8'h00, 1, 0, 16'(16'h0600 + i),
                             8'(8'hC0 + i), burst_st(i)));
        tbl.push_back(mk(1, 16'h5555, 8'h00, 0, 0, 16'h0614, 8'hD4, c_G));
        tbl.push_back(mk(1, 16'h5555, 8'h00, 0, 0, 16'h0000, 8'h00, c_R));
        tbl.push_back(mk(1, 16'h5555, 8'h00, 0, 0, 16'h0000, 8'h00, c_I));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            check_state($sformatf("vec%0d", i), tbl[i].st);
            @(posedge clk); #1;
        end

        // Reset asserted during the second GRANT cycle aborts at once.
        drive(mk(1, 16'h7777, 8'h00, 1, 0, 16'h0800, 8'hEE, c_I));
        @(negedge clk); check_state("rst.idle", c_I);
        @(posedge clk); #1;
        @(negedge clk); check_state("rst.halt", c_H);
        @(posedge clk); #1;
        @(negedge clk); check_state("rst.g1", c_G);
        @(posedge clk); #1;
        check_state("rst.g2", c_G);
        #1 res = 1'b1;
        #1 check_state("rst.abort", c_I);
        @(posedge clk); #1;
        dma_req = 1'b0;
        res     = 1'b0;
        @(negedge clk); check_state("rst.after", c_I);
        @(posedge clk); #1;
        @(negedge clk); check_state("rst.norel", c_I);
        @(posedge clk); #1;
        dma_req = 1'b1;
        @(negedge clk); check_state("rst.req", c_I);
        @(posedge clk); #1;
        @(negedge clk); check_state("rst.rehalt", c_H);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
